// File: rtl/uc_arbiter.sv
// Unit-clause arbiter: round-robin collection of implied literals from the
// BCP processors, assignment-table check, broadcast of fresh assignments,
// conflict detection and quiescence (done) detection.
module uc_arbiter #(
  parameter int NUM_PE  = 4,
  parameter int LIT_W   = 16,
  parameter int VAR_MAX = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic [NUM_PE-1:0]         ucq_in_empty,
  input  logic [NUM_PE*LIT_W-1:0]   ucq_in_lit,
  output logic [NUM_PE-1:0]         ucq_in_pop,
  input  logic [NUM_PE-1:0]         ucq_out_full,
  output logic                      ucq_out_push,
  output logic [LIT_W-1:0]          ucq_out_lit,
  input  logic [NUM_PE-1:0]         pe_stall,
  output logic                      conflict,
  output logic [LIT_W-1:0]          conflict_lit,
  output logic                      done,
  output logic                      err,
  output logic [$clog2(VAR_MAX):0]  assign_cnt
);

  localparam int          PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int          VI_W  = $clog2(VAR_MAX);
  localparam int          CNT_W = VI_W + 1;
  localparam int unsigned NPE   = NUM_PE;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_CONFLICT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     rr_q, rr_d;
  logic [VAR_MAX-1:0]   asg_q, asg_d;
  logic [VAR_MAX-1:0]   neg_q, neg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           qcnt_q, qcnt_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 conf_q, conf_d;
  logic [LIT_W-1:0]     clit_q, clit_d;
  logic [LIT_W-1:0]     olit_q, olit_d;
  logic                 rdy_q, rdy_d;

  logic                 gnt_vld;
  logic [PTR_W-1:0]     gnt_idx;
  logic [PTR_W-1:0]     scan_cand;
  int unsigned          scan_idx;
  logic [LIT_W-1:0]     head_lit;
  logic                 lit_neg;
  logic [LIT_W-1:0]     lit_mag;
  logic                 lit_ok;
  logic [VI_W-1:0]      var_idx;
  logic                 can_grant;
  logic                 quiet;

  // Round-robin search: first non-empty queue at or above rr_q, wrapping.
  always_comb begin
    gnt_vld   = 1'b0;
    gnt_idx   = '0;
    scan_idx  = 0;
    scan_cand = '0;
    for (int unsigned k = 0; k < NPE; k++) begin
      scan_idx  = (32'(rr_q) + k) % NPE;
      scan_cand = PTR_W'(scan_idx);
      if (!gnt_vld && !ucq_in_empty[scan_cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_cand;
      end
    end
  end

  // Decode the granted head literal into magnitude, sign and validity.
  always_comb begin
    head_lit = ucq_in_lit[gnt_idx*LIT_W +: LIT_W];
    lit_neg  = head_lit[LIT_W-1];
    lit_mag  = lit_neg ? (~head_lit + LIT_W'(1)) : head_lit;
    lit_ok   = (head_lit != '0) && (lit_mag < LIT_W'(VAR_MAX));
    var_idx  = lit_mag[VI_W-1:0];
  end

  // Grant gating: rdy_q keeps pops off for the cycle following reset/clear.
  assign can_grant = (state_q == ST_RUN) && rdy_q && !rst && !clear &&
                     !(|ucq_out_full) && gnt_vld;
  assign quiet     = (&ucq_in_empty) && (&pe_stall);

  // FSM next state, table update and combinational pop/push outputs.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    asg_d        = asg_q;
    neg_d        = neg_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    conf_d       = conf_q;
    clit_d       = clit_q;
    olit_d       = olit_q;
    rdy_d        = 1'b1;
    ucq_in_pop   = '0;
    ucq_out_push = 1'b0;

    if (can_grant) begin
      ucq_in_pop[gnt_idx] = 1'b1;
      rr_d = (gnt_idx == PTR_W'(NUM_PE - 1)) ? '0 : gnt_idx + PTR_W'(1);
      if (!lit_ok) begin
        err_d = 1'b1;
      end else if (!asg_q[var_idx]) begin
        ucq_out_push   = 1'b1;
        asg_d[var_idx] = 1'b1;
        neg_d[var_idx] = lit_neg;
        cnt_d          = cnt_q + CNT_W'(1);
        olit_d         = head_lit;
      end else if (neg_q[var_idx] != lit_neg) begin
        conf_d  = 1'b1;
        clit_d  = head_lit;
        state_d = ST_CONFLICT;
      end
    end

    ucq_out_lit = ucq_out_push ? head_lit : olit_q;

    if (state_q == ST_RUN && quiet) begin
      qcnt_d = (qcnt_q == 2'd2) ? 2'd2 : qcnt_q + 2'd1;
    end else begin
      qcnt_d = 2'd0;
    end
    // done_q mirrors "counter at 2 in RUN" so it lines up with qcnt_q.
    done_d = (qcnt_d == 2'd2) && (state_d == ST_RUN);
  end

  // State registers; rst and clear share the same synchronous effect.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= ST_RUN;
      rr_q    <= '0;
      asg_q   <= '0;
      neg_q   <= '0;
      cnt_q   <= '0;
      qcnt_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      conf_q  <= 1'b0;
      clit_q  <= '0;
      olit_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      asg_q   <= asg_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      qcnt_q  <= qcnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      conf_q  <= conf_d;
      clit_q  <= clit_d;
      olit_q  <= olit_d;
      rdy_q   <= rdy_d;
    end
  end

  assign conflict     = conf_q;
  assign conflict_lit = clit_q;
  assign done         = done_q;
  assign err          = err_q;
  assign assign_cnt   = cnt_q;

endmodule

// File: doc/uc_arbiter.md
UC_ARBITER -- requirements
Module: uc_arbiter

Interface
REQ-001 Parameter NUM_PE, default 4: number of BCP processors sharing the arbiter (2..8).
REQ-002 Parameter LIT_W, default 16: signed two's-complement literal width; value 0 is invalid.
REQ-003 Parameter VAR_MAX, default 64: variable table depth; valid variables are 1..VAR_MAX-1; VAR_MAX <= 2^(LIT_W-1).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 clear  in  1  synchronous soft clear of table, flags and FSM; same effect as rst.
REQ-007 ucq_in_empty  in  NUM_PE  per-PE implication queue empty.
REQ-008 ucq_in_lit  in  NUM_PE*LIT_W  per-PE queue head literal; PE i at bits [i*LIT_W +: LIT_W].
REQ-009 ucq_in_pop  out  NUM_PE  one-hot pop to the granted implication queue.
REQ-010 ucq_out_full  in  NUM_PE  per-PE broadcast queue full.
REQ-011 ucq_out_push  out  1  push to every PE broadcast queue.
REQ-012 ucq_out_lit  out  LIT_W  literal broadcast with ucq_out_push.
REQ-013 pe_stall  in  NUM_PE  PE has no in-flight work.
REQ-014 conflict  out  1  sticky conflict flag.
REQ-015 conflict_lit  out  LIT_W  literal that caused the conflict.
REQ-016 done  out  1  system quiescent without conflict.
REQ-017 err  out  1  sticky: invalid literal dropped.
REQ-018 assign_cnt  out  $clog2(VAR_MAX)+1  number of variables currently assigned.

Function
REQ-019 FSM states RUN and CONFLICT; rst/clear enters RUN.
REQ-020 In RUN, a grant occurs in a cycle when at least one ucq_in_empty bit is 0 and all ucq_out_full bits are 0; otherwise ucq_in_pop = 0.
REQ-021 Grant is round-robin: search starts at rr_ptr, first non-empty PE upward with wrap wins; after a grant rr_ptr <= grant+1 mod NUM_PE.
REQ-022 On grant, ucq_in_pop[grant] = 1 in the same cycle (combinational); the granted literal L is classified combinationally against the table in that cycle.
REQ-023 var = |L|; L = 0 or var >= VAR_MAX: pop, no push, err <= 1.
REQ-024 Table entry unassigned: ucq_out_push = 1 and ucq_out_lit = L in the grant cycle; entry <= {assigned=1, polarity=sign(L)}; assign_cnt increments.
REQ-025 Entry assigned with same polarity: pop only, no push, no state change (duplicate drop).
REQ-026 Entry assigned with opposite polarity: pop, no push, conflict <= 1, conflict_lit <= L, FSM -> CONFLICT.
REQ-027 At most one grant, one push and one table write per cycle.
REQ-028 In CONFLICT: ucq_in_pop = 0, ucq_out_push = 0, done = 0; leave only via rst or clear.
REQ-029 Quiescence counter: in RUN, counts consecutive cycles with all ucq_in_empty = 1 and all pe_stall = 1, saturating at 2; any other cycle resets it to 0.
REQ-030 done = 1 (registered) while counter = 2 and FSM = RUN; deasserts the cycle after any queue becomes non-empty or any PE leaves stall.
REQ-031 ucq_out_lit holds its last value when ucq_out_push = 0.
REQ-032 rst and clear take priority over a same-cycle grant: no pop, no push, no table write.

Reset
REQ-033 On rst or clear: all table entries unassigned, rr_ptr = 0, counter = 0, conflict = 0, conflict_lit = 0, err = 0, done = 0, assign_cnt = 0, ucq_out_lit = 0, FSM = RUN.
REQ-034 During and one cycle after reset, ucq_in_pop = 0 and ucq_out_push = 0.

Verification
REQ-035 PE0 head +5, others empty, no full -> same cycle pop[0]=1, push=1, lit=+5; assign_cnt=1.
REQ-036 PE1 and PE2 both non-empty, rr_ptr=0 -> grant PE1 then PE2 on consecutive cycles; rr_ptr ends at 3.
REQ-037 +5 assigned, PE3 pushes +5 -> pop[3]=1, push=0, assign_cnt unchanged; then -5 -> conflict=1, conflict_lit=-5, later pops suppressed until clear.
REQ-038 ucq_out_full[2]=1 with PE0 non-empty -> no pop, no push until full drops, then grant next cycle.
REQ-039 Literal 0 or +64 (VAR_MAX=64) -> popped, no push, err=1 sticky through subsequent valid grants.
REQ-040 All empty and all pe_stall=1 for 2 cycles -> done=1; PE0 becomes non-empty -> done=0 next cycle.
